// File: rtl/clause_array.sv
// Clause storage/evaluation array: per-slot literal storage with combinational
// sat/unit detection, registered implication/backtrack output and insert index.
module clause_slot #(
  parameter int NUM_VARS    = 8,
  parameter int WIDTH_C_LEN = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr,
  input  logic [WIDTH_C_LEN-1:0]   len_in,
  input  logic [NUM_VARS-1:0][1:0] lit_in,
  input  logic [NUM_VARS-1:0][1:0] state,
  output logic                     empty,
  output logic                     unit,
  output logic [NUM_VARS-1:0]      umask,
  output logic [NUM_VARS-1:0][1:0] lit
);
  logic [WIDTH_C_LEN-1:0] len_q;
  logic sat, one, many;

  always_ff @(posedge clk) begin
    if (!rst) begin
      lit   <= '0;
      len_q <= '0;
    end else if (wr) begin
      lit   <= lit_in;
      len_q <= len_in;
    end
  end

  assign empty = (len_q == '0);

  // 11 literals count as absent, 11 states count as free
  always_comb begin
    sat   = 1'b0;
    one   = 1'b0;
    many  = 1'b0;
    umask = '0;
    for (int k = 0; k < NUM_VARS; k++) begin
      if ((lit[k] == 2'b01 && state[k] == 2'b01) || (lit[k] == 2'b10 && state[k] == 2'b10))
        sat = 1'b1;
      if ((lit[k] == 2'b01 || lit[k] == 2'b10) && (state[k] == 2'b00 || state[k] == 2'b11)) begin
        if (one) many = 1'b1;
        one      = 1'b1;
        umask[k] = 1'b1;
      end
    end
  end

  assign unit = !empty && !sat && one && !many;
endmodule

module clause_array #(
  parameter int NUM_CLAUSES      = 8,
  parameter int NUM_VARS         = 8,
  parameter int WIDTH_VAR_STATES = 30,
  parameter int WIDTH_C_LEN      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CLAUSES-1:0]  wr_i,
  input  logic [4:0]              clause_len_i,
  input  logic [NUM_VARS*3-1:0]   var_value_i,
  output logic [NUM_VARS*3-1:0]   var_value_o,
  output logic [NUM_CLAUSES-1:0]  learntc_insert_index_o,
  input  logic                    apply_impl_i,
  input  logic                    apply_bkt_i
);
  logic [NUM_VARS-1:0][1:0]                    val;
  logic [NUM_VARS-1:0]                         flag;
  logic [NUM_CLAUSES-1:0]                      empty, unit;
  logic [NUM_CLAUSES-1:0][NUM_VARS-1:0]        umask;
  logic [NUM_CLAUSES-1:0][NUM_VARS-1:0][1:0]   lit;
  logic [NUM_VARS-1:0]                         imp_hit;
  logic [NUM_VARS-1:0][1:0]                    imp_pol;
  logic [NUM_VARS*3-1:0]                       vv_nxt;
  logic [NUM_CLAUSES-1:0]                      idx_nxt;
  logic                                        unused_ok;

  assign unused_ok = ^{clause_len_i[4:WIDTH_C_LEN], WIDTH_VAR_STATES != 0};

  always_comb begin
    for (int k = 0; k < NUM_VARS; k++) begin
      val[k]  = var_value_i[3*k +: 2];
      flag[k] = var_value_i[3*k+2];
    end
  end

  // val doubles as the literal write data since both live in field bits [1:0]
  for (genvar g = 0; g < NUM_CLAUSES; g++) begin : g_slot
    clause_slot #(.NUM_VARS(NUM_VARS), .WIDTH_C_LEN(WIDTH_C_LEN)) u_slot (
      .clk    (clk),
      .rst    (rst),
      .wr     (wr_i[g]),
      .len_in (clause_len_i[WIDTH_C_LEN-1:0]),
      .lit_in (val),
      .state  (val),
      .empty  (empty[g]),
      .unit   (unit[g]),
      .umask  (umask[g]),
      .lit    (lit[g])
    );
  end

  // descending scan so the lowest-index unit clause is the last writer
  always_comb begin
    imp_hit = '0;
    imp_pol = '0;
    for (int k = 0; k < NUM_VARS; k++) begin
      for (int c = NUM_CLAUSES-1; c >= 0; c--) begin
        if (unit[c] && umask[c][k]) begin
          imp_hit[k] = 1'b1;
          imp_pol[k] = lit[c][k];
        end
      end
    end
  end

  always_comb begin
    vv_nxt = var_value_i;
    if (wr_i == '0) begin
      for (int k = 0; k < NUM_VARS; k++) begin
        if (apply_bkt_i) begin
          if (flag[k]) vv_nxt[3*k +: 3] = 3'b000;
        end else if (apply_impl_i && imp_hit[k]) begin
          vv_nxt[3*k +: 3] = {1'b1, imp_pol[k]};
        end
      end
    end
  end

  always_comb begin
    idx_nxt = '0;
    for (int c = NUM_CLAUSES-1; c >= 0; c--) begin
      if (empty[c]) begin
        idx_nxt    = '0;
        idx_nxt[c] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      var_value_o            <= '0;
      learntc_insert_index_o <= '0;
    end else begin
      var_value_o            <= vv_nxt;
      learntc_insert_index_o <= idx_nxt;
    end
  end
endmodule

// File: tb/tb_clause_array.sv
// Randomized bench for clause_array against a clause-level reference model,
// with directed scenarios whose results are pinned to hand-computed literals.
module tb_clause_array;
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  wr;
  logic [4:0]  clen;
  logic [23:0] vin, vout;
  logic [7:0]  idx;
  logic        impl, bkt;

  always #5 clk = ~clk;

  clause_array dut (
    .clk                    (clk),
    .rst                    (rst),
    .wr_i                   (wr),
    .clause_len_i           (clen),
    .var_value_i            (vin),
    .var_value_o            (vout),
    .learntc_insert_index_o (idx),
    .apply_impl_i           (impl),
    .apply_bkt_i            (bkt)
  );

  logic [1:0]  mlit [8][8];
  logic [3:0]  mlen [8];
  logic [23:0] exp_vv, pin_vv;
  logic [7:0]  exp_idx, pin_idx;
  logic        chk_en = 1'b0, pin_vv_en = 1'b0, pin_idx_en = 1'b0;
  int          vectors = 0, fails = 0;

  // unit = non-empty, no literal true, exactly one literal on a free variable
  function automatic bit is_unit(input int c, input logic [23:0] st, output int uv);
    int nfree = 0;
    bit sat = 0;
    uv = -1;
    if (mlen[c] == 4'd0) return 0;
    for (int k = 0; k < 8; k++) begin
      logic [1:0] l = mlit[c][k];
      logic [1:0] v = st[3*k +: 2];
      if (l == 2'b01 || l == 2'b10) begin
        if (v == l) sat = 1;
        else if (v == 2'b00 || v == 2'b11) begin nfree++; uv = k; end
      end
    end
    return !sat && nfree == 1;
  endfunction

  function automatic logic [23:0] model_vv();
    logic [23:0] r = vin;
    int uv;
    if (wr != 8'd0) return vin;
    if (bkt) begin
      for (int k = 0; k < 8; k++) if (vin[3*k+2]) r[3*k +: 3] = 3'b000;
    end else if (impl) begin
      for (int k = 0; k < 8; k++)
        for (int c = 0; c < 8; c++)
          if (is_unit(c, vin, uv) && uv == k) begin
            r[3*k +: 3] = {1'b1, mlit[c][k]};
            break;
          end
    end
    return r;
  endfunction

  function automatic logic [7:0] model_idx();
    for (int s = 0; s < 8; s++) if (mlen[s] == 4'd0) return 8'(1 << s);
    return 8'd0;
  endfunction

  function automatic logic [23:0] rnd_fields(input int p_zero);
    logic [23:0] r;
    for (int k = 0; k < 8; k++)
      r[3*k +: 3] = (int'($urandom_range(99)) < p_zero) ? 3'b000 : 3'($urandom);
    return r;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      vectors++;
      if (vout !== exp_vv) begin
        fails++;
        $display("FAIL var_value_o: got %h expected %h at %0t", vout, exp_vv, $time);
      end
      vectors++;
      if (idx !== exp_idx) begin
        fails++;
        $display("FAIL insert_index: got %b expected %b at %0t", idx, exp_idx, $time);
      end
      if (pin_vv_en) begin
        vectors++;
        if (vout !== pin_vv) begin
          fails++;
          $display("FAIL pinned var_value_o: got %h expected %h at %0t", vout, pin_vv, $time);
        end
      end
      if (pin_idx_en) begin
        vectors++;
        if (idx !== pin_idx) begin
          fails++;
          $display("FAIL pinned insert_index: got %b expected %b at %0t", idx, pin_idx, $time);
        end
      end
    end
  end

  task automatic tick();
    logic [23:0] nv;
    logic [7:0]  ni;
    if (!rst) begin nv = '0; ni = '0; end
    else begin nv = model_vv(); ni = model_idx(); end
    @(posedge clk);
    exp_vv  = nv;
    exp_idx = ni;
    chk_en  = 1'b1;
    if (!rst) begin
      for (int s = 0; s < 8; s++) begin
        mlen[s] = 4'd0;
        for (int k = 0; k < 8; k++) mlit[s][k] = 2'b00;
      end
    end else begin
      for (int s = 0; s < 8; s++)
        if (wr[s]) begin
          mlen[s] = clen[3:0];
          for (int k = 0; k < 8; k++) mlit[s][k] = vin[3*k +: 2];
        end
    end
    @(negedge clk);
    #1;
    pin_vv_en  = 1'b0;
    pin_idx_en = 1'b0;
  endtask

  task automatic wr_slot(input int s, input logic [4:0] len, input logic [23:0] lits);
    wr = 8'(1 << s); clen = len; vin = lits;
    tick();
    wr = 8'd0; vin = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0; wr = 8'd0; vin = '0; impl = 1'b0; bkt = 1'b0;
    tick(); tick();
    rst = 1'b1;
  endtask

  task automatic pin_idx_tick(input logic [7:0] v);
    pin_idx = v; pin_idx_en = 1'b1;
    tick();
  endtask

  task automatic pin_vv_tick(input logic [23:0] v);
    pin_vv = v; pin_vv_en = 1'b1;
    tick();
  endtask

  initial begin
    logic [4:0] lens [8];
    rst = 1'b0; wr = 8'd0; clen = 5'd0; vin = '0; impl = 1'b0; bkt = 1'b0;
    lens = '{5'd2, 5'd3, 5'd3, 5'd3, 5'd3, 5'd0, 5'd0, 5'd0};
    for (int s = 0; s < 8; s++) mlen[s] = 4'd0;
    @(negedge clk); #1;
    do_reset();
    pin_vv = '0; pin_vv_en = 1'b1;
    pin_idx_tick(8'b0000_0001);

    for (int s = 0; s < 8; s++) wr_slot(s, lens[s], rnd_fields(60));
    tick();
    pin_idx_tick(8'b0010_0000);

    for (int s = 0; s < 8; s++) wr_slot(s, 5'(1 + $urandom_range(14)), rnd_fields(60));
    pin_idx_tick(8'b0000_0000);
    wr_slot(3, 5'd0, rnd_fields(60));
    pin_idx_tick(8'b0000_1000);

    // slot 0 = {x0 neg, x2 pos}; x0 true implies x2 true
    do_reset();
    wr_slot(0, 5'd2, 24'h000042);
    vin = 24'h000001; impl = 1'b1;
    pin_vv_tick(24'h000141);
    // backtrack wins over implication
    vin = 24'h000068; bkt = 1'b1;
    pin_vv_tick(24'h000040);
    bkt = 1'b0; impl = 1'b0;

    // satisfied clause implies nothing
    do_reset();
    wr_slot(0, 5'd2, 24'h000009);
    vin = 24'h000001; impl = 1'b1;
    pin_vv_tick(24'h000001);
    impl = 1'b0;

    // reset during a write discards it
    rst = 1'b0; wr = 8'hff; clen = 5'd5; vin = rnd_fields(50);
    tick();
    rst = 1'b1; wr = 8'd0; vin = '0;
    pin_idx_tick(8'b0000_0001);

    for (int i = 0; i < 3000; i++) begin
      rst  = ($urandom_range(199) != 0);
      wr   = ($urandom_range(3) == 0) ? 8'($urandom) : 8'd0;
      clen = ($urandom_range(3) == 0) ? {1'($urandom), 4'd0} : 5'($urandom);
      vin  = (wr != 8'd0) ? rnd_fields(70) : rnd_fields(30);
      impl = 1'($urandom);
      bkt  = ($urandom_range(3) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
